// File: rtl/addr_initiator.sv
// addr_initiator: single-outstanding command initiator for an addressed
// responder bus. Each command is broadcast for one SETUP cycle, then the
// matching strobe is held through ACCESS until the responder pulses done.
// The result is held in RESP until the consumer takes it.
// Optional feature: define ADDR_INITIATOR_TIMEOUT_EN to compile in an ACCESS
// watchdog that aborts with rsp_error after TIMEOUT_CYCLES cycles without done.
//
//  state    | meaning
//  ---------+--------------------------------------------------------
//  S_IDLE   | waiting for a command, cmd_ready high
//  S_SETUP  | address/data driven, strobes low (one cycle)
//  S_ACCESS | one strobe held high until done (or watchdog expiry)
//  S_RESP   | rsp_valid high until rsp_ready handshake
module addr_initiator #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic [ADDR_WIDTH-1:0] active_address,
  output logic                  read_enable,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_error
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rd_en_q;
  logic                  wr_en_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rdata_q;

`ifdef ADDR_INITIATOR_TIMEOUT_EN
  // Down-counter loaded on ACCESS entry; terminal count 0 marks the last
  // allowed ACCESS cycle.
  localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q;
  logic [7:0] tmo_d;
  logic       error_q;

  // Decremented watchdog value for the next ACCESS cycle.
  assign tmo_d = tmo_q - 8'd1;
`endif

  // Transaction sequencer with all bus and response outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
`ifdef ADDR_INITIATOR_TIMEOUT_EN
      tmo_q       <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            write_q     <= cmd_write;
            addr_q      <= cmd_address;
            wdata_q     <= cmd_wdata;
            cmd_ready_q <= 1'b0;
            state_q     <= S_SETUP;
          end
        end
        S_SETUP: begin
          rd_en_q <= ~write_q;
          wr_en_q <= write_q;
`ifdef ADDR_INITIATOR_TIMEOUT_EN
          tmo_q   <= TMO_LOAD;
`endif
          state_q <= S_ACCESS;
        end
        S_ACCESS: begin
          // done has priority over a simultaneous watchdog expiry.
          if (done) begin
            rdata_q     <= write_q ? '0 : read_data;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
`ifdef ADDR_INITIATOR_TIMEOUT_EN
            error_q     <= 1'b0;
`endif
            state_q     <= S_RESP;
          end
`ifdef ADDR_INITIATOR_TIMEOUT_EN
          else if (tmo_q == 8'd0) begin
            rdata_q     <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            error_q     <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            tmo_q <= tmo_d;
          end
`endif
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign active_address = addr_q;
  assign write_data     = wdata_q;
  assign read_enable    = rd_en_q;
  assign write_enable   = wr_en_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rdata_q;
`ifdef ADDR_INITIATOR_TIMEOUT_EN
  assign rsp_error      = error_q;
`else
  assign rsp_error      = 1'b0;
`endif

endmodule

// File: tb/tb_addr_initiator.sv
// Testbench for addr_initiator: directed and randomized transactions checked
// against a transaction-level expectation (strobe length, response payload,
// error flag) derived from the command and the responder's done timing.
module tb_addr_initiator;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int TO = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_address;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] active_address;
  logic          read_enable;
  logic          write_enable;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;
  logic          done;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_error;

  int n_chk = 0;
  int n_err = 0;

  addr_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_wdata(cmd_wdata),
    .active_address(active_address), .read_enable(read_enable),
    .write_enable(write_enable), .write_data(write_data),
    .read_data(read_data), .done(done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_cmd_ready"}, cmd_ready, 0);
    check_val({tag, "_rd_en"}, read_enable, 0);
    check_val({tag, "_wr_en"}, write_enable, 0);
    check_val({tag, "_addr"}, active_address, 0);
    check_val({tag, "_wdata"}, write_data, 0);
    check_val({tag, "_rsp_valid"}, rsp_valid, 0);
    check_val({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check_val({tag, "_rsp_error"}, rsp_error, 0);
  endtask

  // done_at: ACCESS cycle on which done is given (0 = never); bp: RESP cycles
  // with rsp_ready low before the handshake cycle.
  task automatic run_txn(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                         input int done_at, input logic [DW-1:0] rd, input int bp);
    int            exp_cyc;
    logic          exp_err;
    logic [DW-1:0] exp_rd;
    int            en_cnt;
    int            k;
    bit            fin;
    exp_err = 1'b0;
    exp_cyc = done_at;
`ifdef ADDR_INITIATOR_TIMEOUT_EN
    if (done_at == 0 || done_at > TO) begin
      exp_err = 1'b1;
      exp_cyc = TO;
    end
`endif
    exp_rd = (wr || exp_err) ? '0 : rd;

    @(posedge clk); #1;
    check_val("idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = addr; cmd_wdata = wd;

    // SETUP cycle: command inputs scrambled and a stray done must be ignored.
    @(posedge clk); #1;
    cmd_valid = 1'($urandom_range(0, 1)); cmd_write = ~wr;
    cmd_address = AW'($urandom); cmd_wdata = DW'($urandom);
    done = 1'b1; read_data = DW'($urandom);
    @(negedge clk);
    check_val("setup_ready", cmd_ready, 0);
    check_val("setup_rd_en", read_enable, 0);
    check_val("setup_wr_en", write_enable, 0);
    check_val("setup_addr", active_address, addr);
    check_val("setup_wdata", write_data, wd);
    check_val("setup_rsp_valid", rsp_valid, 0);

    en_cnt = 0; k = 0; fin = 1'b0;
    while (!fin) begin
      @(posedge clk); #1;
      k++;
      done = (k == done_at);
      read_data = (k == done_at) ? rd : DW'($urandom);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_address = AW'($urandom); cmd_wdata = DW'($urandom);
      @(negedge clk);
      if (read_enable || write_enable) en_cnt++;
      check_val("access_wr_en", write_enable, wr);
      check_val("access_rd_en", read_enable, !wr);
      check_val("access_addr", active_address, addr);
      check_val("access_wdata", write_data, wd);
      check_val("access_rsp_valid", rsp_valid, 0);
      if (k == exp_cyc) fin = 1'b1;
      if (k >= 64) begin
        check_val("access_budget", k, exp_cyc);
        fin = 1'b1;
      end
    end
    check_val("enable_cycles", en_cnt, exp_cyc);

    // RESP: held under backpressure; stray done and a new command are ignored.
    for (int b = 0; b <= bp; b++) begin
      @(posedge clk); #1;
      done = 1'($urandom_range(0, 1)); read_data = DW'($urandom);
      cmd_valid = 1'b1; cmd_write = 1'($urandom_range(0, 1));
      rsp_ready = (b == bp);
      @(negedge clk);
      check_val("resp_valid", rsp_valid, 1);
      check_val("resp_rdata", rsp_rdata, exp_rd);
      check_val("resp_error", rsp_error, exp_err);
      check_val("resp_rd_en", read_enable, 0);
      check_val("resp_wr_en", write_enable, 0);
      check_val("resp_ready", cmd_ready, 0);
      check_val("resp_addr", active_address, addr);
      check_val("resp_wdata", write_data, wd);
    end

    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b0; done = 1'b0;
    @(negedge clk);
    check_val("post_rsp_valid", rsp_valid, 0);
    check_val("post_ready", cmd_ready, 1);
    check_val("post_addr", active_address, addr);
    check_val("post_wdata", write_data, wd);
    check_val("post_wr_en", write_enable, 0);
  endtask

  task automatic stray_done_idle();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      done = 1'b1; read_data = DW'($urandom);
      @(negedge clk);
      check_val("idle_done_rsp_valid", rsp_valid, 0);
      check_val("idle_done_ready", cmd_ready, 1);
      check_val("idle_done_rd_en", read_enable, 0);
    end
    @(posedge clk); #1;
    done = 1'b0;
  endtask

  task automatic reset_mid_access();
    @(posedge clk); #1;
    check_val("rst_idle_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_address = 4'h9; cmd_wdata = 8'h33;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_access2_rd_en", read_enable, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_rel_ready_low", cmd_ready, 0);
    check_val("rst_rel_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    check_val("rst_rel_ready_high", cmd_ready, 1);
    check_val("rst_rel_rsp_valid2", rsp_valid, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int max_done;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0;
    cmd_wdata = '0; read_data = '0; done = 1'b0; rsp_ready = 1'b0;
    #2;
    check_reset_outputs("por");
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("por_ready_low", cmd_ready, 0);
    @(posedge clk); #1;
    check_val("por_ready_high", cmd_ready, 1);

    run_txn(1'b0, 4'h3, 8'h00, 3, 8'hA5, 0);
    run_txn(1'b1, 4'h7, 8'h5C, 1, 8'hEE, 0);
    run_txn(1'b0, 4'hC, 8'h12, 2, 8'h3C, 4);
    stray_done_idle();
`ifdef ADDR_INITIATOR_TIMEOUT_EN
    run_txn(1'b0, 4'h2, 8'h00, 0, 8'h77, 1);
    run_txn(1'b1, 4'h4, 8'h99, 0, 8'h11, 0);
    run_txn(1'b0, 4'h5, 8'h00, TO, 8'h6B, 0);
    max_done = TO + 5;
`else
    run_txn(1'b0, 4'h5, 8'h00, 20, 8'h6B, 0);
    max_done = 12;
`endif
    for (int t = 0; t < 20; t++) begin
      run_txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
              int'($urandom_range(1, max_done)), DW'($urandom),
              int'($urandom_range(0, 3)));
    end
    reset_mid_access();
    run_txn(1'b0, 4'hA, 8'h00, 1, 8'h5A, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
